// File: rtl/execute_muldiv_pkg.sv
// Shared types for the execute-stage HI/LO unit: decoded op encodings,
// datapath word type, FSM state enum and the divider step count.
package execute_muldiv_pkg;

  typedef logic [31:0] word_t;

  // Decoded op codes; values follow the MIPS SPECIAL funct field.
  typedef enum logic [5:0] {
    OP_MFHI  = 6'h10,
    OP_MTHI  = 6'h11,
    OP_MFLO  = 6'h12,
    OP_MTLO  = 6'h13,
    OP_MULT  = 6'h18,
    OP_MULTU = 6'h19,
    OP_DIV   = 6'h1A,
    OP_DIVU  = 6'h1B,
    OP_ADD   = 6'h20
  } decoded_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } muldiv_state_t;

  localparam int DIV_STEPS = 32;

endpackage

// File: rtl/execute_muldiv_div_iter.sv
// Radix-2 restoring divider core on unsigned magnitudes. One step per
// step_i cycle; quot_o/rem_o show the value after the step taken this cycle,
// so the caller can commit the final result on the same edge as the last step.
module execute_muldiv_div_iter
  import execute_muldiv_pkg::*;
(
  input  logic  clk,
  input  logic  resetn,
  input  logic  start_i,
  input  logic  step_i,
  input  word_t dividend_i,
  input  word_t divisor_i,
  output word_t quot_o,
  output word_t rem_o,
  output logic  last_o
);

  // acc_q = {partial remainder, dividend bits being replaced by quotient bits}
  logic [63:0] acc_q, acc_d;
  word_t       dvs_q;
  logic [5:0]  cnt_q;
  logic [64:0] shifted;
  logic [32:0] diff;

  // One restoring step: shift left, try subtracting the divisor from the top.
  always_comb begin
    shifted = {acc_q, 1'b0};
    diff    = shifted[64:32] - {1'b0, dvs_q};
    if (diff[32]) acc_d = shifted[63:0];
    else          acc_d = {diff[31:0], shifted[31:1], 1'b1};
  end

  assign quot_o = acc_d[31:0];
  assign rem_o  = acc_d[63:32];
  assign last_o = (cnt_q == 6'(DIV_STEPS - 1));

  // Load operands on start, otherwise advance one step when enabled.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (start_i) begin
      acc_q <= {32'b0, dividend_i};
      dvs_q <= divisor_i;
      cnt_q <= '0;
    end else if (step_i) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + 6'd1;
    end
  end

endmodule

// File: rtl/execute_muldiv.sv
// Execute-stage HI/LO unit: MULT/MULTU through a fixed-latency multiplier
// pipe, DIV/DIVU through the iterative divider, MTHI/MTLO in one cycle.
// HI/LO are only ever written together with the done_o pulse.
//
// state | meaning
// IDLE  | accepting ops; MTHI/MTLO complete here
// MUL   | multiplier pipe in flight, MUL_LAT cycles
// DIV   | divider stepping, DIV_STEPS cycles, sign fixup on the last
module execute_muldiv
  import execute_muldiv_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid_i,
  input  decoded_op_t op_i,
  input  word_t       a_i,
  input  word_t       b_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        done_o,
  output word_t       hi_o,
  output word_t       lo_o
);

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  muldiv_state_t state_q;
  word_t         hi_q, lo_q;
  logic          done_q;
  logic [63:0]   mul_a_q, mul_b_q, prod_q;
  logic [CNT_W-1:0] mul_cnt_q;
  logic          q_neg_q, r_neg_q;

  logic          accept, is_div, is_mul, div_signed, a_neg, b_neg;
  word_t         abs_a, abs_b;
  logic [63:0]   mul_prod, mul_res, ext_a, ext_b;
  logic          div_step, div_last;
  word_t         quot_nx, rem_nx, quot_fix, rem_fix;

  // Operand preparation for the op presented this cycle.
  always_comb begin
    accept     = valid_i & ~flush_i & (state_q == IDLE);
    is_div     = (op_i == OP_DIV) || (op_i == OP_DIVU);
    is_mul     = (op_i == OP_MULT) || (op_i == OP_MULTU);
    div_signed = (op_i == OP_DIV);
    a_neg      = div_signed & a_i[31];
    b_neg      = div_signed & b_i[31];
    abs_a      = a_neg ? word_t'(-a_i) : a_i;
    abs_b      = b_neg ? word_t'(-b_i) : b_i;
    // Low 64 bits of the extended product are correct for both signednesses.
    ext_a      = (op_i == OP_MULT) ? {{32{a_i[31]}}, a_i} : {32'b0, a_i};
    ext_b      = (op_i == OP_MULT) ? {{32{b_i[31]}}, b_i} : {32'b0, b_i};
  end

  assign mul_prod = mul_a_q * mul_b_q;
  assign mul_res  = (MUL_LAT == 1) ? mul_prod : prod_q;

  assign div_step = (state_q == DIV) & ~flush_i;
  assign quot_fix = q_neg_q ? word_t'(-quot_nx) : quot_nx;
  assign rem_fix  = r_neg_q ? word_t'(-rem_nx)  : rem_nx;

  execute_muldiv_div_iter u_div (
    .clk        (clk),
    .resetn     (resetn),
    .start_i    (accept & is_div),
    .step_i     (div_step),
    .dividend_i (abs_a),
    .divisor_i  (abs_b),
    .quot_o     (quot_nx),
    .rem_o      (rem_nx),
    .last_o     (div_last)
  );

  // Main FSM with HI/LO commit; flush always wins and discards the result.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      prod_q    <= '0;
      mul_cnt_q <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (flush_i) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (accept) begin
              if (op_i == OP_MTHI) begin
                hi_q   <= a_i;
                done_q <= 1'b1;
              end else if (op_i == OP_MTLO) begin
                lo_q   <= a_i;
                done_q <= 1'b1;
              end else if (is_mul) begin
                mul_a_q   <= ext_a;
                mul_b_q   <= ext_b;
                mul_cnt_q <= CNT_W'(MUL_LAT - 1);
                state_q   <= MUL;
              end else if (is_div) begin
                q_neg_q <= a_neg ^ b_neg;
                r_neg_q <= a_neg;
                state_q <= DIV;
              end
            end
          end
          MUL: begin
            prod_q <= mul_prod;
            if (mul_cnt_q == '0) begin
              hi_q    <= mul_res[63:32];
              lo_q    <= mul_res[31:0];
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              mul_cnt_q <= mul_cnt_q - 1'b1;
            end
          end
          DIV: begin
            if (div_last) begin
              hi_q    <= rem_fix;
              lo_q    <= quot_fix;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule
